// File: rtl/surf_debug_pkg.sv
// Shared widths, FSM state encoding and small helpers for the debug-bus arbiter.
package surf_debug_pkg;

  localparam int DBG_WIDTH = 35;
  localparam int NREQ      = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_OWN    = 2'd2,
    ST_OVR    = 2'd3
  } arb_state_t;

  function automatic logic [NREQ-1:0] onehot4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/surf_rr_arb4.sv
// Four-way round-robin winner picker: the requester just after `last` has top
// priority and `last` itself has the lowest.
module surf_rr_arb4
  import surf_debug_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [1:0]      last,
  output logic [NREQ-1:0] gnt,
  output logic [1:0]      idx,
  output logic            any
);

  logic [1:0] cand;

  always_comb begin
    idx  = last;
    any  = 1'b0;
    cand = last;
    for (int k = 1; k <= NREQ; k++) begin
      cand = last + 2'(k);
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
    gnt = any ? onehot4(idx) : '0;
  end

endmodule

// File: rtl/surf_debug_arbiter.sv
// Debug-bus arbiter: round-robin ownership with tenure pre-emption, an operator
// override path, and a settle window before the selected word is flagged valid.
module surf_debug_arbiter
  import surf_debug_pkg::*;
#(
  parameter int SETTLE   = 2,
  parameter int MAX_HOLD = 1024
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic [NREQ-1:0]          req_i,
  input  logic [NREQ-1:0]          done_i,
  input  logic [NREQ*DBG_WIDTH-1:0] dbg_i,
  input  logic                     ovr_en_i,
  input  logic [1:0]               ovr_sel_i,
  output logic [NREQ-1:0]          grant_o,
  output logic [1:0]               sel_o,
  output logic [DBG_WIDTH-1:0]     dbg_o,
  output logic                     dbg_valid_o,
  output logic                     preempt_o
);

  arb_state_t         state_reg;
  logic [1:0]         rst_sync_reg;
  logic               run;
  logic               ovr_reg;
  logic [1:0]         ptr_reg;
  logic [3:0]         settle_cnt_reg;
  logic [15:0]        tenure_reg;
  logic [NREQ-1:0]    arb_gnt;
  logic [1:0]         arb_idx;
  logic               arb_any;
  logic               owner_rel;
  logic               hold_exp;
  logic [DBG_WIDTH-1:0] src [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_src
      assign src[gi] = dbg_i[gi*DBG_WIDTH +: DBG_WIDTH];
    end
  endgenerate

  // Reset asserts immediately but releases only after two clean clock edges.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) rst_sync_reg <= '0;
    else          rst_sync_reg <= {rst_sync_reg[0], 1'b1};
  end
  assign run = rst_sync_reg[1];

  // The current owner is masked out so a release hands over to someone else.
  surf_rr_arb4 u_arb (
    .req  (req_i & ~grant_o),
    .last (ptr_reg),
    .gnt  (arb_gnt),
    .idx  (arb_idx),
    .any  (arb_any)
  );

  assign owner_rel = (|(done_i & grant_o)) || !(|(req_i & grant_o));
  assign hold_exp  = (tenure_reg >= 16'(MAX_HOLD - 1)) && arb_any;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg      <= ST_IDLE;
      ovr_reg        <= 1'b0;
      ptr_reg        <= 2'd3;
      settle_cnt_reg <= '0;
      tenure_reg     <= '0;
      grant_o        <= '0;
      sel_o          <= '0;
      dbg_valid_o    <= 1'b0;
      preempt_o      <= 1'b0;
    end else if (run) begin
      ovr_reg   <= ovr_en_i;
      preempt_o <= 1'b0;
      if (ovr_en_i && !ovr_reg) begin
        state_reg      <= ST_SETTLE;
        grant_o        <= '0;
        sel_o          <= ovr_sel_i;
        settle_cnt_reg <= '0;
        dbg_valid_o    <= 1'b0;
      end else if (!ovr_en_i && ovr_reg) begin
        state_reg   <= ST_IDLE;
        grant_o     <= '0;
        dbg_valid_o <= 1'b0;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (arb_any) begin
              state_reg      <= ST_SETTLE;
              grant_o        <= arb_gnt;
              sel_o          <= arb_idx;
              ptr_reg        <= arb_idx;
              settle_cnt_reg <= '0;
              tenure_reg     <= '0;
            end
          end
          ST_SETTLE: begin
            if (settle_cnt_reg == 4'(SETTLE - 1)) begin
              state_reg   <= ovr_en_i ? ST_OVR : ST_OWN;
              dbg_valid_o <= 1'b1;
            end else begin
              settle_cnt_reg <= settle_cnt_reg + 4'd1;
            end
          end
          ST_OWN: begin
            if (owner_rel || hold_exp) begin
              preempt_o   <= !owner_rel;
              dbg_valid_o <= 1'b0;
              if (arb_any) begin
                state_reg      <= ST_SETTLE;
                grant_o        <= arb_gnt;
                sel_o          <= arb_idx;
                ptr_reg        <= arb_idx;
                settle_cnt_reg <= '0;
                tenure_reg     <= '0;
              end else begin
                state_reg <= ST_IDLE;
                grant_o   <= '0;
              end
            end else if (tenure_reg != 16'(MAX_HOLD)) begin
              tenure_reg <= tenure_reg + 16'd1;
            end
          end
          ST_OVR: begin
            if (ovr_sel_i != sel_o) begin
              state_reg      <= ST_SETTLE;
              sel_o          <= ovr_sel_i;
              settle_cnt_reg <= '0;
              dbg_valid_o    <= 1'b0;
            end
          end
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) dbg_o <= '0;
    else          dbg_o <= src[sel_o];
  end

endmodule

// File: doc/surf_debug_arbiter.md
SURF_DEBUG_ARBITER -- requirements
Module: surf_debug_arbiter

Interface
REQ-001 SHALL have parameter SETTLE, default 2: cycles after a select change before dbg_valid_o asserts (1..15).
REQ-002 SHALL have parameter MAX_HOLD, default 1024: tenure cycles after which a granted owner is pre-empted if another request is pending (16..65535).
REQ-003 SHALL have port clk_i  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n_i  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_i  input  4  per-requester debug-bus request, level.
REQ-006 SHALL have port done_i  input  4  per-requester release pulse, honoured only for the current owner.
REQ-007 SHALL have port dbg_i  input  140  four packed 35-bit debug sources, source n at [35n+34:35n].
REQ-008 SHALL have port ovr_en_i  input  1  operator (VIO) override enable.
REQ-009 SHALL have port ovr_sel_i  input  2  override source select.
REQ-010 SHALL have port grant_o  output  4  one-hot grant, zero when no owner or override.
REQ-011 SHALL have port sel_o  output  2  registered source select.
REQ-012 SHALL have port dbg_o  output  35  registered selected debug word.
REQ-013 SHALL have port dbg_valid_o  output  1  dbg_o stable and attributable to sel_o.
REQ-014 SHALL have port preempt_o  output  1  one-cycle pulse when an owner is pre-empted.

Function
REQ-015 SHALL implement states IDLE, SETTLE, OWN, OVR.
REQ-016 IDLE: no request -> stay; any req_i -> pick winner round-robin starting after last owner, set sel_o to winner, grant_o to winner, go SETTLE.
REQ-017 SETTLE: count SETTLE cycles with dbg_valid_o low, then go OWN (or OVR when override active).
REQ-018 OWN: dbg_valid_o high; owner done_i or owner req_i deasserting -> release; tenure counter reaching MAX_HOLD with another req_i pending -> release and pulse preempt_o.
REQ-019 Release SHALL re-arbitrate in the same cycle: another pending request -> SETTLE with new winner, none -> IDLE with grant_o zero and sel_o held.
REQ-020 Round-robin: the released owner SHALL have lowest priority in the next arbitration; pointer advances only on grant.
REQ-021 dbg_o SHALL equal dbg_i slice selected by sel_o, registered, one cycle latency; SETTLE >= 1 guarantees the first valid word is from the new source.
REQ-022 Override: ovr_en_i rising in any state SHALL clear grant_o, load sel_o from ovr_sel_i, go SETTLE then OVR; ovr_sel_i change in OVR SHALL re-enter SETTLE.
REQ-023 ovr_en_i falling SHALL go IDLE and re-arbitrate next cycle; override beats any simultaneous request or done_i.
REQ-024 done_i from a non-owner, and done_i with the same-cycle req_i of that owner, SHALL be ignored except owner done_i, which always releases.
REQ-025 Tenure counter SHALL saturate at MAX_HOLD while no other request is pending, and clear on every grant.

Reset
REQ-026 Asserted rst_n_i SHALL force IDLE, grant_o=0, sel_o=0, dbg_o=0, dbg_valid_o=0, preempt_o=0, RR pointer=3 (requester 0 first), counters 0, regardless of mid-tenure or SETTLE.
REQ-027 Reset deassertion SHALL be synchronised; first arbitration no earlier than the second clk_i edge after release.

Structure
REQ-028 State encoding, DBG_WIDTH=35 and NREQ=4 SHALL live in shared package surf_debug_pkg.
REQ-029 The round-robin winner logic SHALL be sub-module surf_rr_arb4 (req, last-owner pointer -> one-hot winner, index).

Verification
REQ-030 req_i=0001 from reset -> grant_o=0001 next cycle, sel_o=0, dbg_valid_o high exactly SETTLE+1 cycles after req.
REQ-031 req_i=1111 with immediate done_i from each owner -> grant order 0,1,2,3,0.
REQ-032 owner 2 holds, req_i[1] raised -> after MAX_HOLD cycles preempt_o pulses once, grant_o moves to 0010.
REQ-033 ovr_en_i=1, ovr_sel_i=3 while owner 1 in OWN -> grant_o=0 next cycle, sel_o=3, dbg_o=dbg_i[139:105] when valid; ovr_en_i=0 -> owner re-granted.
REQ-034 rst_n_i low during SETTLE -> all outputs zero asynchronously, IDLE after release.
REQ-035 done_i from non-owner 3 while owner 0 -> no state change, grant_o stays 0001.
